// File: rtl/call_dispatcher.sv
// Elevator call side: button conditioning, call latches and SCAN target
// selection for the movement block.
module call_dispatcher #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic [2:0] floor_onehot,
  input  logic       door_open,
  input  logic       arrive_ack,
  input  logic       sos_mode,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic       target_valid,
  output logic [2:0] target_floor,
  output logic       dir_up,
  output logic       idle
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN
  } state_t;

  localparam logic [3:0] DEB_M1 = 4'(DEBOUNCE_CYCLES - 1);

  logic [2:0]      s1_q, s1_d;
  logic [2:0]      s2_q, s2_d;
  logic [2:0]      deb_q, deb_d;
  logic [2:0]      rise_q, rise_d;
  logic [2:0][3:0] cnt_q, cnt_d;
  logic [2:0]      call_q, call_d;
  logic [2:0]      tgt_q, tgt_d;
  state_t          state_q, state_d;

  logic       floor_ok;
  logic [2:0] set_v, clr_v;
  logic [2:0] above, below, here;
  logic [2:0] lo_above, hi_below;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      rise_q  <= '0;
      cnt_q   <= '0;
      call_q  <= '0;
      tgt_q   <= '0;
      state_q <= S_IDLE;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
      call_q  <= call_d;
      tgt_q   <= tgt_d;
      state_q <= state_d;
    end
  end

  // Sync + debounce; counter only runs while the sync value disagrees
  always_comb begin
    s1_d  = {button3, button2, button1};
    s2_d  = s1_q;
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= DEB_M1) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else if (cnt_q[i] != 4'hF) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
    rise_d = deb_d & ~deb_q;
  end

  assign floor_ok = (floor_onehot == 3'b001) ||
                    (floor_onehot == 3'b010) ||
                    (floor_onehot == 3'b100);

  always_comb begin
    set_v = rise_q & ~(floor_onehot & {3{door_open}});
    clr_v = (arrive_ack && floor_ok) ? floor_onehot : 3'b000;
    call_d = (call_q | set_v) & ~clr_v;
    if (sos_mode) call_d = '0;
  end

  always_comb begin
    above = '0;
    below = '0;
    here  = call_q & floor_onehot;
    if (floor_ok) begin
      unique case (1'b1)
        floor_onehot[0]: above = call_q & 3'b110;
        floor_onehot[1]: begin
          above = call_q & 3'b100;
          below = call_q & 3'b001;
        end
        floor_onehot[2]: below = call_q & 3'b011;
      endcase
    end
    lo_above = above[1] ? 3'b010 : (above[2] ? 3'b100 : 3'b000);
    hi_below = below[1] ? 3'b010 : (below[0] ? 3'b001 : 3'b000);
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    if (sos_mode) begin
      state_d = S_IDLE;
      tgt_d   = '0;
    end else if (floor_ok) begin
      unique case (state_q)
        S_IDLE: begin
          if (here != 3'b000) begin
            tgt_d   = floor_onehot;
            state_d = floor_onehot[2] ? S_DOWN : S_UP;
          end else if (above != 3'b000) begin
            tgt_d   = lo_above;
            state_d = S_UP;
          end else if (below != 3'b000) begin
            tgt_d   = hi_below;
            state_d = S_DOWN;
          end else begin
            tgt_d   = '0;
          end
        end
        S_UP: begin
          if (above != 3'b000) begin
            tgt_d = lo_above;
          end else if (here != 3'b000) begin
            tgt_d = floor_onehot;
          end else if (below != 3'b000) begin
            tgt_d   = hi_below;
            state_d = S_DOWN;
          end else begin
            tgt_d   = '0;
            state_d = S_IDLE;
          end
        end
        S_DOWN: begin
          if (below != 3'b000) begin
            tgt_d = hi_below;
          end else if (here != 3'b000) begin
            tgt_d = floor_onehot;
          end else if (above != 3'b000) begin
            tgt_d   = lo_above;
            state_d = S_UP;
          end else begin
            tgt_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: begin
          tgt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign led1         = call_q[0];
  assign led2         = call_q[1];
  assign led3         = call_q[2];
  assign idle         = (state_q == S_IDLE);
  assign dir_up       = (state_q == S_UP);
  assign target_valid = !idle && (tgt_q != 3'b000);
  assign target_floor = target_valid ? tgt_q : 3'b000;

endmodule

// File: tb/tb_call_dispatcher.sv
// Directed bench for call_dispatcher: debounce latency, SCAN targets,
// SOS, invalid floor and asynchronous reset.
module tb_call_dispatcher;

  logic       clk;
  logic       rst_n;
  logic       button1, button2, button3;
  logic [2:0] floor_onehot;
  logic       door_open, arrive_ack, sos_mode;
  logic       led1, led2, led3;
  logic       target_valid;
  logic [2:0] target_floor;
  logic       dir_up, idle;

  int checks = 0;
  int errors = 0;

  call_dispatcher #(.DEBOUNCE_CYCLES(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button1      (button1),
    .button2      (button2),
    .button3      (button3),
    .floor_onehot (floor_onehot),
    .door_open    (door_open),
    .arrive_ack   (arrive_ack),
    .sos_mode     (sos_mode),
    .led1         (led1),
    .led2         (led2),
    .led3         (led3),
    .target_valid (target_valid),
    .target_floor (target_floor),
    .dir_up       (dir_up),
    .idle         (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  function automatic logic [2:0] leds();
    return {led3, led2, led1};
  endfunction

  initial begin
    rst_n = 1'b0;
    {button1, button2, button3} = '0;
    floor_onehot = 3'b001;
    door_open = 1'b0;
    arrive_ack = 1'b0;
    sos_mode = 1'b0;
    tick(2);
    chk("rst_leds", 32'(leds()), 32'h0);
    chk("rst_tv", 32'(target_valid), 32'h0);
    chk("rst_tf", 32'(target_floor), 32'h0);
    chk("rst_dir", 32'(dir_up), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    rst_n = 1'b1;
    tick(1);

    // Latency: edge 6 latch, edge 7 target
    button3 = 1'b1;
    tick(5);
    chk("lat_led3_e5", 32'(led3), 32'h0);
    tick(1);
    chk("lat_led3_e6", 32'(led3), 32'h1);
    chk("lat_tv_e6", 32'(target_valid), 32'h0);
    tick(1);
    chk("lat_tv_e7", 32'(target_valid), 32'h1);
    chk("lat_tf_e7", 32'(target_floor), 32'h4);
    chk("lat_dir_e7", 32'(dir_up), 32'h1);
    button3 = 1'b0;
    do_reset();

    // Glitch shorter than the debounce window
    button2 = 1'b1;
    tick(2);
    button2 = 1'b0;
    tick(8);
    chk("glitch_led2", 32'(led2), 32'h0);
    chk("glitch_idle", 32'(idle), 32'h1);

    // Long hold: one request only
    button2 = 1'b1;
    tick(7);
    chk("hold_led2", 32'(led2), 32'h1);
    chk("hold_tf", 32'(target_floor), 32'h2);
    floor_onehot = 3'b010;
    arrive_ack = 1'b1;
    tick(1);
    arrive_ack = 1'b0;
    chk("hold_clr", 32'(led2), 32'h0);
    tick(15);
    chk("hold_once", 32'(led2), 32'h0);
    chk("hold_idle", 32'(idle), 32'h1);
    button2 = 1'b0;
    do_reset();

    // Floor 2 idle, calls 1 and 3 together: tie goes UP
    floor_onehot = 3'b010;
    button1 = 1'b1;
    button3 = 1'b1;
    tick(6);
    chk("tie_leds", 32'(leds()), 32'h5);
    tick(1);
    chk("tie_dir", 32'(dir_up), 32'h1);
    chk("tie_tf", 32'(target_floor), 32'h4);
    button1 = 1'b0;
    button3 = 1'b0;

    // Same-floor press with door open is already satisfied
    door_open = 1'b1;
    button2 = 1'b1;
    tick(8);
    chk("same_led2", 32'(led2), 32'h0);
    button2 = 1'b0;
    door_open = 1'b0;
    tick(6);

    // Arrive at 3 then reverse toward 1
    floor_onehot = 3'b100;
    tick(1);
    chk("arr_tf_pre", 32'(target_floor), 32'h4);
    arrive_ack = 1'b1;
    tick(1);
    arrive_ack = 1'b0;
    chk("arr_led3", 32'(led3), 32'h0);
    chk("arr_dir_hold", 32'(dir_up), 32'h1);
    tick(1);
    chk("arr_down", 32'(dir_up), 32'h0);
    chk("arr_notidle", 32'(idle), 32'h0);
    chk("arr_tf", 32'(target_floor), 32'h1);

    // Invalid floor code freezes scheduler and clears
    floor_onehot = 3'b011;
    arrive_ack = 1'b1;
    tick(1);
    arrive_ack = 1'b0;
    tick(2);
    chk("inv_tf", 32'(target_floor), 32'h1);
    chk("inv_leds", 32'(leds()), 32'h1);
    chk("inv_idle", 32'(idle), 32'h0);

    // SOS wipes calls; presses during SOS are dropped
    floor_onehot = 3'b010;
    button3 = 1'b1;
    tick(7);
    chk("sos_pre", 32'(leds()), 32'h5);
    button3 = 1'b0;
    tick(6);
    sos_mode = 1'b1;
    tick(1);
    chk("sos_leds", 32'(leds()), 32'h0);
    chk("sos_tv", 32'(target_valid), 32'h0);
    chk("sos_idle", 32'(idle), 32'h1);
    button1 = 1'b1;
    tick(8);
    button1 = 1'b0;
    tick(8);
    sos_mode = 1'b0;
    tick(3);
    chk("sos_exit_leds", 32'(leds()), 32'h0);
    chk("sos_exit_idle", 32'(idle), 32'h1);

    // Asynchronous reset mid-sweep
    floor_onehot = 3'b001;
    button3 = 1'b1;
    tick(7);
    chk("sweep_tf", 32'(target_floor), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_leds", 32'(leds()), 32'h0);
    chk("arst_tv", 32'(target_valid), 32'h0);
    chk("arst_tf", 32'(target_floor), 32'h0);
    chk("arst_dir", 32'(dir_up), 32'h0);
    chk("arst_idle", 32'(idle), 32'h1);
    button3 = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/call_dispatcher.md
Name: call_dispatcher

Overview:
- Request side of the elevator call interface. Conditions the raw floor buttons, latches pending calls and drives the call LEDs.
- Computes the next target floor for the movement block using a direction-holding (SCAN) policy.
- Clears calls when the movement block acknowledges arrival with the door open.
- Sits between the board buttons and the movement logic, on the slow divided clock.

Parameters:
- DEBOUNCE_CYCLES, 3: consecutive stable synchronized samples required before a button level change is accepted (range 1..15; counter is 4 bits).

Ports:
- clk  input  1  divided system clock.
- rst_n  input  1  asynchronous active-low reset.
- button1, button2, button3  input  1 each  raw floor call buttons, active-high, asynchronous to clk.
- floor_onehot  input  3  current cabin floor from movement; bit0 = floor 1, bit2 = floor 3.
- door_open  input  1  door open indication from movement.
- arrive_ack  input  1  single-cycle pulse from movement: cabin stopped at floor_onehot and serviced it.
- sos_mode  input  1  emergency active.
- led1, led2, led3  output  1 each  pending call latches.
- target_valid  output  1  a target is being presented.
- target_floor  output  3  one-hot target; 000 when target_valid=0.
- dir_up  output  1  1 = current sweep is upward; 0 = downward or idle.
- idle  output  1  scheduler in IDLE state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Synchronizers, debounce counters, debounced levels and call latches cleared.
  - FSM = IDLE.
  - Outputs: led* = 0, target_valid = 0, target_floor = 000, dir_up = 0, idle = 1.
- Reset mid-operation discards all pending calls. No call survives reset.
- Input conditioning, per button:
  - 2-flop synchronizer, then debounce.
  - The debounced level changes only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing sample clears the counter.
  - A debounced rising edge produces a one-cycle request pulse. Release produces nothing.
  - Holding a button produces exactly one request.
- Latency: count the first edge that samples the button high as edge 1.
  - Debounced level is high after edge 2+DEBOUNCE_CYCLES.
  - Latch sets at edge 3+DEBOUNCE_CYCLES.
  - Target updates at edge 4+DEBOUNCE_CYCLES.
- Call latches:
  - Set on a request pulse.
  - Not set if the requested floor equals floor_onehot and door_open=1 (call already satisfied).
  - Cleared when arrive_ack=1 for the floor indicated by floor_onehot.
  - Same-floor set and clear in the same cycle: clear wins.
- Emergency: while sos_mode=1,
  - all latches are held at 0 and request pulses are discarded;
  - FSM is forced to IDLE with target_valid = 0.
  - Debouncing continues. Presses made during SOS are not replayed on exit.
- Invalid floor: if floor_onehot is not exactly one-hot, the FSM state, target outputs and latch-clear logic hold their values. Latch set still operates.
- Scheduler FSM, registered, evaluated each cycle from the latch state:
  - IDLE:
    - No pending call: stay.
    - Call at current floor: target it, go UP if floor<3, else DOWN.
    - Otherwise go toward the nearest pending call. Tie (at floor 2, calls at 1 and 3): UP.
  - UP:
    - Target = lowest pending floor above current.
    - If none above but the current floor is pending, target = current.
    - Else if any pending below, go DOWN.
    - Else go IDLE.
  - DOWN: mirror of UP (highest pending below current).
  - target_valid = 1 in UP/DOWN whenever a target exists; dir_up = 1 in UP only.
  - Target and direction change one cycle after the latch change that causes them.
- Widths: floors encoded one-hot 3 bits throughout. No arithmetic beyond the 4-bit debounce counter, which saturates and never wraps.

Test Plan:
- Reset, then hold button3 high with floor_onehot=001, DEBOUNCE_CYCLES=3 → led3=1 at edge 6; target_valid=1, target_floor=100, dir_up=1 at edge 7.
- Button2 glitch high for 2 cycles then low → led2 stays 0 and no target change; button held 20 cycles → exactly one latch set.
- Cabin at floor 2, UP state, calls at 1 and 3 → target 100. arrive_ack with floor_onehot=100 → led3 clears, next cycle DOWN with target 001.
- Idle at floor 2, calls 1 and 3 latched in the same cycle → UP, target 100. Same-floor press with door_open=1 → latch not set.
- Calls at 1 and 3 pending, sos_mode=1 → next cycle leds 000, target_valid=0, idle=1; press button1 during SOS, then release sos → no call latched.
- floor_onehot=011 for 3 cycles with arrive_ack pulsed → target and leds unchanged. Also assert rst_n low mid-sweep → all outputs at reset values immediately, without waiting for a clock edge.
